imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time IMEM loader: reads a length-prefixed, XOR-checked byte stream, assembles
// little-endian 32-bit words and writes them to IMEM while holding the fetch stage.
module imem_loader #(
    parameter int unsigned          PC_WIDTH   = 32,
    parameter int unsigned          INST_WIDTH = 32,
    parameter int unsigned          MAX_WORDS  = 1024,
    parameter logic [PC_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [PC_WIDTH-1:0]   wr_addr,
    output logic [INST_WIDTH-1:0] wr_data,
    output logic                  core_hold,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StErr
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic                  wr_en_q, wr_en_d;
    logic [PC_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [INST_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  in_ready_q, in_ready_d;
    logic                  core_hold_q, core_hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  hs;
    logic [15:0]           len_full;

    assign hs       = in_valid & in_ready_q;
    assign len_full = {in_data, len_q[7:0]};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        // Address advances the cycle the write is presented; the next word is >= 3 cycles away.
        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + PC_WIDTH'(4);
        end

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (load_start) begin
                    state_d    = StLenLo;
                    len_d      = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                    byte_cnt_d = '0;
                    wr_addr_d  = BASE_ADDR;
                end
            end
            StLenLo: begin
                if (hs) begin
                    len_d[7:0] = in_data;
                    csum_d     = csum_q ^ in_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (hs) begin
                    len_d[15:8] = in_data;
                    csum_d      = csum_q ^ in_data;
                    if (32'(len_full) > MAX_WORDS) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (hs) begin
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = INST_WIDTH'({in_data, asm_q});
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == len_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        asm_d[byte_cnt_q*8 +: 8] = in_data;
                    end
                end
            end
            StCsum: begin
                if (hs) begin
                    state_d = (in_data == csum_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = state_d inside {StLenLo, StLenHi, StData, StCsum};
        core_hold_d = in_ready_d | (state_d == StErr);
        done_d      = (state_d == StDone);
        err_d       = (state_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            word_cnt_q  <= '0;
            csum_q      <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= BASE_ADDR;
            wr_data_q   <= '0;
            in_ready_q  <= 1'b0;
            core_hold_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            csum_q      <= csum_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            in_ready_q  <= in_ready_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IMEM writes are queued as images are sent,
// a negedge monitor pops and compares each write the DUT issues.
module tb_imem_loader;

    localparam logic [31:0] Base = 32'h100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    imem_loader #(
        .PC_WIDTH   (32),
        .INST_WIDTH (32),
        .MAX_WORDS  (1024),
        .BASE_ADDR  (Base)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         wr_cnt = 0;
    int         n_stall = 0;
    logic [7:0] img[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected write: addr %h data %h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        check("start in_ready", 32'(in_ready), 32'd1);
        check("start core_hold", 32'(core_hold), 32'd1);
        check("start done/err", {30'd0, done, err}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit pulse_start);
        int t;
        if (gap > 0) begin
            in_valid = 1'b0;
            for (int i = 0; i < gap; i++) begin
                if (pulse_start && i == 0) load_start = 1'b1;
                @(posedge clk); #1;
                load_start = 1'b0;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
            n_stall++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL handshake timeout: in_ready=0, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic load_image(input int maxgap, input int start_at);
        for (int i = 0; i < img.size(); i++) begin
            send(img[i], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0, i == start_at);
        end
        in_valid = 1'b0;
    endtask

    task automatic push3();
        exp_q.push_back('{addr: Base,          data: 32'h00500093});
        exp_q.push_back('{addr: Base + 32'd4,  data: 32'h00100113});
        exp_q.push_back('{addr: Base + 32'd8,  data: 32'h002081B3});
    endtask

    initial begin
        int w0;
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        // Reset hold with valid and start asserted.
        reset_n = 1'b0; in_valid = 1'b1; load_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst core_hold", 32'(core_hold), 32'd0);
        check("rst done/err", {30'd0, done, err}, 32'd0);
        check("rst wr_addr", wr_addr, Base);
        check("rst wr_data", wr_data, 32'd0);
        reset_n = 1'b1; load_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle in_ready", 32'(in_ready), 32'd0);
        check("idle core_hold", 32'(core_hold), 32'd0);
        in_valid = 1'b0;

        // Single word, checksum 01^13 = 12.
        start();
        exp_q.push_back('{addr: Base, data: 32'h00000013});
        img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        load_image(0, -1);
        check("single done", 32'(done), 32'd1);
        check("single core_hold", 32'(core_hold), 32'd0);
        check("single err", 32'(err), 32'd0);
        check("single in_ready", 32'(in_ready), 32'd0);
        check("single pending", exp_q.size(), 32'd0);
        check("single next addr", wr_addr, Base + 32'd4);

        // Three words back-to-back, checksum D0.
        start();
        push3();
        n_stall = 0;
        img = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                8'hB3, 8'h81, 8'h20, 8'h00, 8'hD0};
        load_image(0, -1);
        check("b2b stalls", n_stall, 32'd0);
        check("b2b done", 32'(done), 32'd1);
        check("b2b err", 32'(err), 32'd0);
        check("b2b pending", exp_q.size(), 32'd0);
        check("b2b next addr", wr_addr, Base + 32'd12);

        // Bad checksum, then recovery.
        start();
        exp_q.push_back('{addr: Base, data: 32'h00000013});
        img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        load_image(0, -1);
        repeat (3) @(posedge clk);
        #1;
        check("badcs err", 32'(err), 32'd1);
        check("badcs core_hold", 32'(core_hold), 32'd1);
        check("badcs done", 32'(done), 32'd0);
        check("badcs pending", exp_q.size(), 32'd0);
        start();
        exp_q.push_back('{addr: Base, data: 32'h00000013});
        img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        load_image(0, -1);
        check("recover done", 32'(done), 32'd1);
        check("recover err", 32'(err), 32'd0);

        // Length bound: N = 0x0401 rejected right after LEN_HI.
        start();
        w0 = wr_cnt;
        img = '{8'h01, 8'h04};
        load_image(0, -1);
        check("maxlen err", 32'(err), 32'd1);
        check("maxlen in_ready", 32'(in_ready), 32'd0);
        check("maxlen done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("maxlen writes", wr_cnt - w0, 32'd0);

        // Empty image: N = 0, checksum 0.
        start();
        w0 = wr_cnt;
        img = '{8'h00, 8'h00, 8'h00};
        load_image(0, -1);
        check("empty done", 32'(done), 32'd1);
        check("empty err", 32'(err), 32'd0);
        check("empty writes", wr_cnt - w0, 32'd0);

        // Random gaps plus a stray load_start during DATA.
        start();
        push3();
        img = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                8'hB3, 8'h81, 8'h20, 8'h00, 8'hD0};
        load_image(5, 6);
        check("stall done", 32'(done), 32'd1);
        check("stall err", 32'(err), 32'd0);
        check("stall pending", exp_q.size(), 32'd0);
        check("stall next addr", wr_addr, Base + 32'd12);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
